mult33_rr_sched: RTL

Round-robin scheduler that shares one pipelined 33x33 Karatsuba multiplier among NUM_REQ requesters. It arbitrates operand requests, drives the multiplier's operand buses, and tracks each issued operation's requester ID through the multiplier latency. Results are buffered in a credit-protected response FIFO. It sits between requester blocks and a single multiplier instance; the multiplier itself is external.

---
 rtl/mult33_rr_sched_if.sv | 30 +++
 rtl/mult33_rr_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult33_rr_sched_if.sv
// Signal bundle between the requesters, the shared 33x33 multiplier and the
// response consumer of mult33_rr_sched.
interface mult33_rr_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*33-1:0] req_a;
    logic [NUM_REQ*33-1:0] req_b;
    logic [32:0]           mul_a;
    logic [32:0]           mul_b;
    logic [65:0]           mul_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [65:0]           rsp_data;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mult33_rr_sched.sv
// Round-robin scheduler sharing one pipelined 33x33 multiplier among NUM_REQ
// requesters, with requester-ID tracking and a credit-protected response FIFO.
module mult33_rr_sched_chk #(
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             wr,
    input logic [CNT_W-1:0] cnt
);
    // A multiplier result must never arrive while the FIFO is full.
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (reset) !(wr && (cnt == CNT_W'(FIFO_DEPTH)))
    );
endmodule

module mult33_rr_sched #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input logic               clk,
    input logic               reset,
    mult33_rr_sched_if.slave  bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 1);

    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        ptr_d;
    logic [MUL_LATENCY-1:0] tag_vld_q;
    logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
    logic [ID_W-1:0]        mem_id_q [FIFO_DEPTH];
    logic [65:0]            mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    logic [OCC_W-1:0]       inflight_s;
    logic [OCC_W-1:0]       occ_s;
    logic                   can_issue_s;
    logic                   found_s;
    logic                   issue_s;
    logic [ID_W-1:0]        idx_s;
    logic [ID_W-1:0]        grant_s;
    logic                   wr_s;
    logic                   pop_s;
    logic                   rsp_valid_s;

    // Credit: every valid tag stage and every buffered entry holds one slot.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            inflight_s = inflight_s + OCC_W'(tag_vld_q[i]);
        end
        occ_s       = inflight_s + OCC_W'(cnt_q);
        can_issue_s = (occ_s < OCC_W'(FIFO_DEPTH));
    end

    // Round-robin search starting at the pointer and wrapping mod NUM_REQ.
    always_comb begin
        grant_s = ptr_q;
        found_s = 1'b0;
        idx_s   = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found_s && bus.req_valid[idx_s]) begin
                grant_s = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        issue_s = !reset && can_issue_s && found_s;
        if (issue_s) begin
            ptr_d = (grant_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_s + ID_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Accept strobe and operand steering; operands are zero when nothing issues.
    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        if (issue_s) begin
            bus.req_ready[grant_s] = 1'b1;
            bus.mul_a = bus.req_a[33 * int'(grant_s) +: 33];
            bus.mul_b = bus.req_b[33 * int'(grant_s) +: 33];
        end else begin
            bus.req_ready = '0;
        end
    end

    assign rsp_valid_s = (cnt_q != '0);
    assign wr_s        = tag_vld_q[MUL_LATENCY-1];
    assign pop_s       = rsp_valid_s && bus.rsp_ready;
    assign cnt_d       = cnt_q + CNT_W'(wr_s) - CNT_W'(pop_s);

    // Response head, forced to zero while the FIFO is empty.
    always_comb begin
        bus.rsp_valid = rsp_valid_s;
        bus.busy      = (occ_s != '0);
        if (rsp_valid_s) begin
            bus.rsp_id   = mem_id_q[rd_ptr_q];
            bus.rsp_data = mem_data_q[rd_ptr_q];
        end else begin
            bus.rsp_id   = '0;
            bus.rsp_data = '0;
        end
    end

    // Control state: RR pointer, tag pipeline, FIFO pointers and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= issue_s;
            tag_id_q[0]  <= grant_s;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_id_q[wr_ptr_q]   <= tag_id_q[MUL_LATENCY-1];
            mem_data_q[wr_ptr_q] <= bus.mul_result;
        end
    end

    mult33_rr_sched_chk #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_s),
        .cnt   (cnt_q)
    );
endmodule
